down_counter_3bit: RTL
======================

DOWN_COUNTER_3BIT -- requirements
Module: down_counter_3bit

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the counter width in bits; legal range is 2 to 16.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port en, input, 1, SHALL be the count enable; Q decrements when high.
REQ-005 Port load, input, 1, SHALL be the synchronous parallel load strobe.
REQ-006 Port din, input, WIDTH, SHALL be the parallel load value.
REQ-007 Port Q, output, WIDTH, SHALL be the registered count value.
REQ-008 Port zero, output, 1, SHALL indicate Q == 0, decoded combinationally from Q.
REQ-009 Port tc, output, 1, SHALL be the borrow/terminal count (en AND Q == 0), combinational, for cascading.

Function
REQ-010 Per-edge priority SHALL be: load, then en, then hold.
REQ-011 load=1 SHALL set Q to din on the next edge regardless of en; tc still follows the pre-load Q and en.
REQ-012 load=0, en=1, Q != 0 SHALL set Q to Q-1 on the next edge; latency is 1 cycle.
REQ-013 Decrement SHALL be synchronous borrow-chain logic: bit i toggles iff en=1 and bits i-1..0 are all 0; bit 0 toggles whenever en=1.
REQ-014 load=0, en=1, Q == 0 SHALL wrap Q to the wrap value (REQ-020/021) on the next edge.
REQ-015 load=0, en=0 SHALL hold Q unchanged.
REQ-016 tc SHALL be high for exactly the cycles in which en=1 and Q=0, so a downstream stage enabled by tc decrements once per full wrap of this stage.
REQ-017 zero and tc SHALL have no registered delay relative to Q and en.
REQ-018 All WIDTH bits SHALL update on the same edge; no ripple clocking.

Reset
REQ-019 reset=0 SHALL immediately, without waiting for clk, force Q=0; zero=1 and tc=en follow from this.
REQ-020 Reset SHALL force the reload register (if present) to all ones.
REQ-021 Reset deassertion SHALL be sampled synchronously; the first count or load occurs on the first rising clk edge with reset=1.
REQ-022 Reset asserted mid-count or coincident with load SHALL override both; din is not captured.

Configuration
REQ-023 Macro DOWN_COUNTER_AUTO_RELOAD_EN defined SHALL add a WIDTH-bit reload register, written with din on every load, and the wrap value SHALL be the reload register contents.
REQ-024 Macro DOWN_COUNTER_AUTO_RELOAD_EN undefined SHALL omit the reload register, and the wrap value SHALL be all ones (2^WIDTH-1).
REQ-025 With the macro defined and no load since reset, behaviour SHALL be identical to the macro undefined.

Verification (WIDTH=3)
REQ-026 reset low, then high, en=1 for 9 edges -> Q = 0,7,6,5,4,3,2,1,0,7; tc high only in cycles where Q=0.
REQ-027 load=1, din=5, en=1 on one edge, then en=1 -> Q=5, then 4; load wins over en.
REQ-028 Q=3, en=0 for 4 edges -> Q holds 3; tc=0; zero=0.
REQ-029 reset pulsed low between clk edges while Q=6 -> Q=0 before the next edge; after release, en=1 -> Q=7.
REQ-030 Two instances, upper en = lower tc, both reset, lower en=1 for 16 edges -> {upper,lower} counts 0,63,62,...,48 as a 6-bit down counter.
REQ-031 AUTO_RELOAD_EN defined: load din=4, en=1 for 6 edges -> Q = 4,3,2,1,0,4,3; macro undefined, same stimulus -> 4,3,2,1,0,7,6.

Source files
------------

// File: rtl/down_counter_3bit.sv
// down_counter_3bit: WIDTH-bit synchronous down counter with load, zero flag and cascade borrow (tc).
// Optional DOWN_COUNTER_AUTO_RELOAD_EN: wrap to the last loaded value instead of all ones.
`default_nettype none

module down_counter_3bit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             tc
);

  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] q_next;
  logic             borrow;

  // Borrow chain: a bit toggles when counting and every lower bit is already zero.
  always_comb begin
    toggle    = '0;
    borrow    = en;
    toggle[0] = en;
    for (int i = 1; i < WIDTH; i++) begin
      borrow    = borrow & ~Q[i-1];
      toggle[i] = borrow;
    end
  end

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '1;
    end else if (load) begin
      reload_q <= din;
    end
  end

  assign wrap_val = reload_q;
`else
  assign wrap_val = '1;
`endif

  assign zero = (Q == '0);
  assign tc   = en & zero;

  always_comb begin
    q_next = Q;
    if (load) begin
      q_next = din;
    end else if (en) begin
      q_next = zero ? wrap_val : (Q ^ toggle);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= '0;
    end else begin
      Q <= q_next;
    end
  end

endmodule

`default_nettype wire
